// File: rtl/latch_write_arbiter.sv
// Round-robin arbiter sharing one bank of D latches among several write clients.
// Each write is sequenced setup -> open -> hold, then the latch output is checked.
module latch_write_arbiter #(
   parameter int unsigned NREQ      = 4,
   parameter int unsigned DW        = 8,
   parameter int unsigned EN_CYCLES = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ*DW-1:0] wdata,
   output logic [NREQ-1:0]    gnt,
   output logic [NREQ-1:0]    done,
   output logic               err,
   output logic [DW-1:0]      lat_d,
   output logic               lat_en,
   input  logic [DW-1:0]      lat_q,
   output logic               busy
);

   localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned CW = (EN_CYCLES > 0) ? $clog2(EN_CYCLES + 1) : 1;

   // Elaboration-time parameter sanity.
   if (EN_CYCLES < 1) begin : g_en_chk
      $error("latch_write_arbiter: EN_CYCLES must be at least 1");
   end
   if (NREQ < 2 || NREQ > 16) begin : g_nreq_chk
      $error("latch_write_arbiter: NREQ must be in 2..16");
   end

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      OPEN  = 3'd2,
      HOLD  = 3'd3,
      CHECK = 3'd4
   } state_t;

   state_t          state, state_nxt;
   logic [PW-1:0]   owner, owner_nxt;
   logic [PW-1:0]   ptr, ptr_nxt;
   logic [CW-1:0]   cnt, cnt_nxt;
   logic [DW-1:0]   data_reg, data_nxt;
   logic [NREQ-1:0] gnt_nxt;
   logic [NREQ-1:0] done_nxt;
   logic            err_nxt;
   logic [DW-1:0]   lat_d_nxt;
   logic            lat_en_nxt;
   logic            busy_nxt;

   logic            found;
   logic [PW-1:0]   pick;

   // Round-robin search starting at the pointer, wrapping past NREQ-1 to 0.
   always_comb begin : p_rr
      int unsigned idx;
      idx   = 0;
      found = 1'b0;
      pick  = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         idx = 32'(ptr) + i;
         if (idx >= NREQ) begin
            idx = idx - NREQ;
         end
         if (!found && req[idx[PW-1:0]]) begin
            found = 1'b1;
            pick  = PW'(idx);
         end
      end
   end

   // Next-state and next-output logic for the write sequencer.
   always_comb begin
      state_nxt = state;
      owner_nxt = owner;
      ptr_nxt   = ptr;
      cnt_nxt   = cnt;
      data_nxt  = data_reg;
      gnt_nxt   = gnt;
      done_nxt  = '0;
      err_nxt   = 1'b0;
      lat_d_nxt = lat_d;

      case (state)
         IDLE: begin
            if (found) begin
               state_nxt = SETUP;
               owner_nxt = pick;
               gnt_nxt   = NREQ'(1) << pick;
               data_nxt  = wdata[32'(pick)*DW +: DW];
               lat_d_nxt = wdata[32'(pick)*DW +: DW];
            end
         end
         SETUP: begin
            state_nxt = OPEN;
            cnt_nxt   = CW'(EN_CYCLES);
         end
         OPEN: begin
            // Counter runs EN_CYCLES..1 so the enable is high exactly EN_CYCLES cycles.
            cnt_nxt = cnt - CW'(1);
            if (cnt == CW'(1)) begin
               state_nxt = HOLD;
            end
         end
         HOLD: begin
            // Latch is closed here, so q is stable; compare result lands in CHECK.
            state_nxt = CHECK;
            done_nxt  = gnt;
            err_nxt   = (lat_q != data_reg);
         end
         CHECK: begin
            state_nxt = IDLE;
            gnt_nxt   = '0;
            if (32'(owner) + 32'd1 >= NREQ) begin
               ptr_nxt = '0;
            end else begin
               ptr_nxt = owner + PW'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
            gnt_nxt   = '0;
         end
      endcase

      lat_en_nxt = (state_nxt == OPEN);
      busy_nxt   = (state_nxt != IDLE);
   end

   // State, bookkeeping and registered outputs; reset drops the enable at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         owner    <= '0;
         ptr      <= '0;
         cnt      <= '0;
         data_reg <= '0;
         gnt      <= '0;
         done     <= '0;
         err      <= 1'b0;
         lat_d    <= '0;
         lat_en   <= 1'b0;
         busy     <= 1'b0;
      end else begin
         state    <= state_nxt;
         owner    <= owner_nxt;
         ptr      <= ptr_nxt;
         cnt      <= cnt_nxt;
         data_reg <= data_nxt;
         gnt      <= gnt_nxt;
         done     <= done_nxt;
         err      <= err_nxt;
         lat_d    <= lat_d_nxt;
         lat_en   <= lat_en_nxt;
         busy     <= busy_nxt;
      end
   end

endmodule

// File: tb/tb_latch_write_arbiter.sv
// Bench for latch_write_arbiter: directed scenarios plus randomized writes
// checked against a transaction-level model with a behavioural latch bank.
module tb_latch_write_arbiter;

   localparam int unsigned NREQ = 4;
   localparam int unsigned DW   = 8;
   localparam int unsigned EN   = 2;

   logic               clk = 1'b0;
   logic               rst_n;
   logic [NREQ-1:0]    req;
   logic [NREQ*DW-1:0] wdata;
   logic [NREQ-1:0]    gnt;
   logic [NREQ-1:0]    done;
   logic               err;
   logic [DW-1:0]      lat_d;
   logic               lat_en;
   logic [DW-1:0]      lat_q;
   logic               busy;

   logic [DW-1:0]      lat_mem;
   logic               force0;

   int checks   = 0;
   int failures = 0;
   int m_ptr    = 0;

   latch_write_arbiter #(.NREQ(NREQ), .DW(DW), .EN_CYCLES(EN)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .req    (req),
      .wdata  (wdata),
      .gnt    (gnt),
      .done   (done),
      .err    (err),
      .lat_d  (lat_d),
      .lat_en (lat_en),
      .lat_q  (lat_q),
      .busy   (busy)
   );

   always #5 clk = ~clk;

   // Behavioural latch bank; force0 models a stuck-at-zero readback.
   always_latch begin
      if (lat_en) lat_mem <= lat_d;
   end
   assign lat_q = force0 ? '0 : lat_mem;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full write from an IDLE starting point; the model predicts winner,
   // cycle-by-cycle enable window, done/err and the pointer advance.
   task automatic txn(input logic [NREQ-1:0] r, input logic [NREQ*DW-1:0] wd,
                      input logic f0, input logic scramble, input logic drop);
      int w;
      logic [DW-1:0] d;
      logic exp_err;
      w = -1;
      for (int k = 0; k < int'(NREQ); k++) begin
         if (w < 0 && r[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
      end
      d       = wd[w*DW +: DW];
      exp_err = ((f0 ? 8'h00 : d) != d);
      req     = r;
      wdata   = wd;
      force0  = f0;
      tick();
      chk("gnt_setup",    32'(gnt),    32'(1) << w);
      chk("lat_d_setup",  32'(lat_d),  32'(d));
      chk("lat_en_setup", 32'(lat_en), 32'd0);
      chk("busy_setup",   32'(busy),   32'd1);
      for (int k = 0; k < int'(EN); k++) begin
         tick();
         chk("lat_en_open", 32'(lat_en), 32'd1);
         chk("gnt_open",    32'(gnt),    32'(1) << w);
         if (scramble && k == 0) wdata = ~wd;
      end
      tick();
      chk("lat_en_hold", 32'(lat_en), 32'd0);
      chk("done_hold",   32'(done),   32'd0);
      chk("lat_d_hold",  32'(lat_d),  32'(d));
      if (drop) req = '0;
      tick();
      chk("done_check", 32'(done), 32'(1) << w);
      chk("err_check",  32'(err),  32'(exp_err));
      chk("gnt_check",  32'(gnt),  32'(1) << w);
      tick();
      chk("gnt_idle",   32'(gnt),   32'd0);
      chk("done_idle",  32'(done),  32'd0);
      chk("err_idle",   32'(err),   32'd0);
      chk("busy_idle",  32'(busy),  32'd0);
      chk("lat_d_idle", 32'(lat_d), 32'(d));
      m_ptr = (w + 1) % NREQ;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req   = '0;
      #1;
      tick();
      rst_n = 1'b1;
      m_ptr = 0;
      tick();
   endtask

   initial begin
      logic [NREQ-1:0]    r;
      logic [NREQ*DW-1:0] wd;
      rst_n  = 1'b0;
      req    = '0;
      wdata  = '0;
      force0 = 1'b0;

      // Reset with no requests: everything quiet.
      tick();
      chk("rst_gnt",    32'(gnt),    32'd0);
      chk("rst_done",   32'(done),   32'd0);
      chk("rst_err",    32'(err),    32'd0);
      chk("rst_lat_d",  32'(lat_d),  32'd0);
      chk("rst_lat_en", 32'(lat_en), 32'd0);
      chk("rst_busy",   32'(busy),   32'd0);
      rst_n = 1'b1;
      tick();
      chk("idle_busy", 32'(busy), 32'd0);

      // Single write from requester 0.
      txn(4'b0001, 32'h1234_56A5, 1'b0, 1'b0, 1'b1);

      // Reset asserted mid-OPEN: enable must drop in the same cycle.
      req   = 4'b0010;
      wdata = 32'h0000_7700;
      tick();
      tick();
      chk("pre_rst_lat_en", 32'(lat_en), 32'd1);
      rst_n = 1'b0;
      req   = '0;
      #1;
      chk("async_lat_en", 32'(lat_en), 32'd0);
      chk("async_gnt",    32'(gnt),    32'd0);
      chk("async_busy",   32'(busy),   32'd0);
      tick();
      rst_n = 1'b1;
      m_ptr = 0;
      tick();
      chk("post_rst_done", 32'(done), 32'd0);
      chk("post_rst_busy", 32'(busy), 32'd0);

      // All requesters held: 0,1,2,3,0 with six-cycle grant spacing.
      for (int i = 0; i < 5; i++) begin
         txn(4'b1111, 32'h4433_2211 + 32'(i), 1'b0, 1'b0, 1'b0);
      end
      req = '0;
      tick();
      chk("quiet_busy", 32'(busy), 32'd0);

      // Stuck-at-zero readback while writing 3C.
      txn(4'b0100, 32'h003C_0000, 1'b1, 1'b0, 1'b1);
      force0 = 1'b0;

      // wdata changed during OPEN and req dropped during HOLD.
      txn(4'b1000, 32'h5A00_0000, 1'b0, 1'b1, 1'b1);
      tick();
      chk("drop_busy", 32'(busy), 32'd0);

      // Pointer wrap: set pointer to 3, then 1001 grants 3 then 0.
      do_reset();
      txn(4'b0100, 32'h0011_0000, 1'b0, 1'b0, 1'b1);
      chk("ptr_model", 32'(m_ptr), 32'd3);
      txn(4'b1001, 32'hC300_00E7, 1'b0, 1'b0, 1'b0);
      txn(4'b1001, 32'hC300_00E7, 1'b0, 1'b0, 1'b1);

      // Randomized writes with optional gaps, scrambles, drops and bad readback.
      for (int i = 0; i < 25; i++) begin
         r  = NREQ'($urandom_range(1, (1 << NREQ) - 1));
         wd = $urandom;
         txn(r, wd, ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)));
         if ($urandom_range(0, 2) == 0) begin
            req = '0;
            tick();
            chk("gap_gnt",  32'(gnt),  32'd0);
            chk("gap_busy", 32'(busy), 32'd0);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
